// File: rtl/multibank_pingpong_ram.sv
// multibank_pingpong_ram: N-bank ring buffer that generalises the two-bank ping-pong RAM.
// The writer fills one bank at a time and hands it over with wr_finish.
// The reader drains the committed banks in fill order and releases each one with rd_finish.
// Each committed bank records its fill length.
// Misuse of either side is latched into a sticky flag until reset.
module multibank_pingpong_ram #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 7,
  parameter  int NBANK  = 2,
  localparam int BW     = (NBANK > 2) ? $clog2(NBANK) : 1,
  localparam int CW     = $clog2(NBANK + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_finish,
  output logic              wr_ready,
  output logic [BW-1:0]     wr_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_finish,
  output logic              rd_ready,
  output logic [BW-1:0]     rd_bank,
  output logic [ADDR_W:0]   rd_len,
  output logic [CW-1:0]     full_cnt,
  output logic              wr_ovf,
  output logic              rd_unf
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [BW-1:0]   LAST_BANK = BW'(NBANK - 1);
  localparam logic [CW-1:0]   ALL_FULL  = CW'(NBANK);

  // Advance a bank index around the ring; NBANK need not be a power of two.
  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BW'(1);
  endfunction

  // Unsigned maximum, used for the high-water length tracker.
  function automatic logic [ADDR_W:0] len_max(input logic [ADDR_W:0] a,
                                              input logic [ADDR_W:0] b);
    return (a > b) ? a : b;
  endfunction

  // Flat {bank, addr} storage so that it maps onto a single block RAM.
  logic [DATA_W-1:0] mem [NBANK*DEPTH];
  logic [ADDR_W:0]   len [NBANK];
  logic [ADDR_W:0]   hw;
  logic [ADDR_W:0]   wa_len;
  logic [ADDR_W:0]   hw_nxt;
  logic [DATA_W-1:0] rd_data_p1;
  logic              wr_ok;
  logic              commit;
  logic              rel_ok;

  // Handshake qualification and high-water update, including a same-cycle write.
  always_comb begin
    wr_ready = (full_cnt != ALL_FULL);
    rd_ready = (full_cnt != '0);
    wr_ok    = wr_en & wr_ready;
    commit   = wr_finish & wr_ready;
    rel_ok   = rd_finish & rd_ready;
    wa_len   = {1'b0, wr_addr} + (ADDR_W+1)'(1);
    hw_nxt   = wr_ok ? len_max(hw, wa_len) : hw;
  end

  assign rd_len  = len[rd_bank];
  assign rd_data = rd_data_p1;

  // Ring control: bank indices, occupancy, fill lengths and the sticky misuse flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= '0;
      rd_bank  <= '0;
      full_cnt <= '0;
      hw       <= '0;
      wr_ovf   <= 1'b0;
      rd_unf   <= 1'b0;
      for (int i = 0; i < NBANK; i++) len[i] <= '0;
    end else begin
      if (commit) begin
        len[wr_bank] <= hw_nxt;
        hw           <= '0;
        wr_bank      <= bank_inc(wr_bank);
      end else begin
        hw <= hw_nxt;
      end
      if (rel_ok) rd_bank <= bank_inc(rd_bank);
      case ({commit, rel_ok})
        2'b10:   full_cnt <= full_cnt + CW'(1);
        2'b01:   full_cnt <= full_cnt - CW'(1);
        default: full_cnt <= full_cnt;
      endcase
      if ((wr_en | wr_finish) & ~wr_ready) wr_ovf <= 1'b1;
      if (rd_finish & ~rd_ready)           rd_unf <= 1'b1;
    end
  end

  // Single write port into the writer's bank; reset only suppresses the strobe.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Read stage p0 -> p1: registered read from the reader's bank, before any advance.
  always_ff @(posedge clk) begin
    if (rst) rd_data_p1 <= '0;
    else     rd_data_p1 <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: tb/tb_multibank_pingpong_ram.sv
// Directed bench for multibank_pingpong_ram with three instances (2, 3 and 4 banks).
// Each instance has its own stimulus, and expected values are hand-computed constants.
module tb_multibank_pingpong_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Two-bank instance signals
  logic [6:0] a_wr_addr = '0;  logic a_wr_en = 0;  logic [7:0] a_wr_data = '0;
  logic a_wr_finish = 0;       logic a_wr_ready;   logic [0:0] a_wr_bank;
  logic [6:0] a_rd_addr = '0;  logic [7:0] a_rd_data;  logic a_rd_finish = 0;
  logic a_rd_ready;            logic [0:0] a_rd_bank;  logic [7:0] a_rd_len;
  logic [1:0] a_full_cnt;      logic a_wr_ovf;     logic a_rd_unf;

  // Three-bank instance signals
  logic [6:0] b_wr_addr = '0;  logic b_wr_en = 0;  logic [7:0] b_wr_data = '0;
  logic b_wr_finish = 0;       logic b_wr_ready;   logic [1:0] b_wr_bank;
  logic [6:0] b_rd_addr = '0;  logic [7:0] b_rd_data;  logic b_rd_finish = 0;
  logic b_rd_ready;            logic [1:0] b_rd_bank;  logic [7:0] b_rd_len;
  logic [1:0] b_full_cnt;      logic b_wr_ovf;     logic b_rd_unf;

  // Four-bank instance signals
  logic [6:0] c_wr_addr = '0;  logic c_wr_en = 0;  logic [7:0] c_wr_data = '0;
  logic c_wr_finish = 0;       logic c_wr_ready;   logic [1:0] c_wr_bank;
  logic [6:0] c_rd_addr = '0;  logic [7:0] c_rd_data;  logic c_rd_finish = 0;
  logic c_rd_ready;            logic [1:0] c_rd_bank;  logic [7:0] c_rd_len;
  logic [2:0] c_full_cnt;      logic c_wr_ovf;     logic c_rd_unf;

  multibank_pingpong_ram #(.DATA_W(8), .ADDR_W(7), .NBANK(2)) u2 (
    .clk(clk), .rst(rst), .wr_addr(a_wr_addr), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .wr_finish(a_wr_finish), .wr_ready(a_wr_ready), .wr_bank(a_wr_bank),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_finish(a_rd_finish),
    .rd_ready(a_rd_ready), .rd_bank(a_rd_bank), .rd_len(a_rd_len),
    .full_cnt(a_full_cnt), .wr_ovf(a_wr_ovf), .rd_unf(a_rd_unf));

  multibank_pingpong_ram #(.DATA_W(8), .ADDR_W(7), .NBANK(3)) u3 (
    .clk(clk), .rst(rst), .wr_addr(b_wr_addr), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_finish(b_wr_finish), .wr_ready(b_wr_ready), .wr_bank(b_wr_bank),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_finish(b_rd_finish),
    .rd_ready(b_rd_ready), .rd_bank(b_rd_bank), .rd_len(b_rd_len),
    .full_cnt(b_full_cnt), .wr_ovf(b_wr_ovf), .rd_unf(b_rd_unf));

  multibank_pingpong_ram #(.DATA_W(8), .ADDR_W(7), .NBANK(4)) u4 (
    .clk(clk), .rst(rst), .wr_addr(c_wr_addr), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .wr_finish(c_wr_finish), .wr_ready(c_wr_ready), .wr_bank(c_wr_bank),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_finish(c_rd_finish),
    .rd_ready(c_rd_ready), .rd_bank(c_rd_bank), .rd_len(c_rd_len),
    .full_cnt(c_full_cnt), .wr_ovf(c_wr_ovf), .rd_unf(c_rd_unf));

  task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for three cycles
    rst = 1'b1;
    tick; tick; tick;
    chk_vec("rst_rd_data", 32'(a_rd_data), 0);
    chk_vec("rst_wr_ready", 32'(a_wr_ready), 1);
    chk_vec("rst_rd_ready", 32'(a_rd_ready), 0);
    rst = 1'b0;
    tick;
    chk_vec("idle_wr_ready", 32'(a_wr_ready), 1);
    chk_vec("idle_rd_ready", 32'(a_rd_ready), 0);
    chk_vec("idle_wr_bank", 32'(a_wr_bank), 0);
    chk_vec("idle_rd_bank", 32'(a_rd_bank), 0);
    chk_vec("idle_full_cnt", 32'(a_full_cnt), 0);
    chk_vec("idle_rd_len", 32'(a_rd_len), 0);
    chk_vec("idle_wr_ovf", 32'(a_wr_ovf), 0);
    chk_vec("idle_rd_unf", 32'(a_rd_unf), 0);

    // Fill bank 0 of the two-bank instance with 10 words, commit, read one back
    for (int a = 0; a < 10; a++) begin
      a_wr_en = 1'b1; a_wr_addr = 7'(a); a_wr_data = 8'(8'h10 + a);
      tick;
    end
    a_wr_en = 1'b0; a_wr_finish = 1'b1;
    tick;
    a_wr_finish = 1'b0;
    chk_vec("fill_full_cnt", 32'(a_full_cnt), 1);
    chk_vec("fill_wr_bank", 32'(a_wr_bank), 1);
    chk_vec("fill_rd_ready", 32'(a_rd_ready), 1);
    chk_vec("fill_rd_bank", 32'(a_rd_bank), 0);
    chk_vec("fill_rd_len", 32'(a_rd_len), 10);
    a_rd_addr = 7'd3;
    tick;
    chk_vec("fill_rd_data", 32'(a_rd_data), 32'h13);

    // Commit bank 1 with one word written in the same cycle; ring becomes full
    a_wr_en = 1'b1; a_wr_addr = 7'd0; a_wr_data = 8'hA5; a_wr_finish = 1'b1;
    tick;
    a_wr_en = 1'b0; a_wr_finish = 1'b0;
    chk_vec("stall_full_cnt", 32'(a_full_cnt), 2);
    chk_vec("stall_wr_ready", 32'(a_wr_ready), 0);
    chk_vec("stall_wr_bank", 32'(a_wr_bank), 0);
    chk_vec("stall_ovf_pre", 32'(a_wr_ovf), 0);
    a_wr_en = 1'b1; a_wr_addr = 7'd3; a_wr_data = 8'hEE;
    tick;
    a_wr_en = 1'b0;
    chk_vec("stall_wr_ovf", 32'(a_wr_ovf), 1);
    chk_vec("stall_full_keep", 32'(a_full_cnt), 2);
    a_rd_addr = 7'd3;
    tick;
    chk_vec("stall_mem_keep", 32'(a_rd_data), 32'h13);
    a_rd_finish = 1'b1;
    tick;
    a_rd_finish = 1'b0;
    chk_vec("rel_full_cnt", 32'(a_full_cnt), 1);
    chk_vec("rel_wr_ready", 32'(a_wr_ready), 1);
    chk_vec("rel_wr_bank", 32'(a_wr_bank), 0);
    chk_vec("rel_rd_bank", 32'(a_rd_bank), 1);
    chk_vec("rel_rd_len", 32'(a_rd_len), 1);
    chk_vec("rel_rd_unf", 32'(a_rd_unf), 0);
    a_rd_addr = 7'd0;
    tick;
    chk_vec("rel_rd_data", 32'(a_rd_data), 32'hA5);

    // Four banks: commit a 6-word bank and an empty bank
    c_wr_en = 1'b1; c_wr_addr = 7'd5; c_wr_data = 8'h55; c_wr_finish = 1'b1;
    tick;
    c_wr_en = 1'b0;
    tick;
    c_wr_finish = 1'b0;
    chk_vec("n4_full_cnt", 32'(c_full_cnt), 2);
    chk_vec("n4_wr_bank", 32'(c_wr_bank), 2);
    chk_vec("n4_rd_len0", 32'(c_rd_len), 6);
    // Commit (with a write at the top address) and release in the same cycle
    c_wr_en = 1'b1; c_wr_addr = 7'd127; c_wr_data = 8'h7F; c_wr_finish = 1'b1;
    c_rd_finish = 1'b1;
    tick;
    c_wr_en = 1'b0; c_wr_finish = 1'b0; c_rd_finish = 1'b0;
    chk_vec("sim_full_cnt", 32'(c_full_cnt), 2);
    chk_vec("sim_wr_bank", 32'(c_wr_bank), 3);
    chk_vec("sim_rd_bank", 32'(c_rd_bank), 1);
    chk_vec("sim_rd_len_empty", 32'(c_rd_len), 0);
    c_rd_finish = 1'b1;
    tick;
    c_rd_finish = 1'b0;
    chk_vec("n4_rd_bank2", 32'(c_rd_bank), 2);
    chk_vec("n4_full_cnt1", 32'(c_full_cnt), 1);
    chk_vec("n4_rd_len128", 32'(c_rd_len), 128);
    c_rd_addr = 7'd127;
    tick;
    chk_vec("n4_rd_data127", 32'(c_rd_data), 32'h7F);
    chk_vec("n4_wr_ovf", 32'(c_wr_ovf), 0);

    // Three banks: seven commit/release rounds tagged with commit order
    for (int k = 0; k < 7; k++) begin
      b_wr_en = 1'b1; b_wr_addr = 7'd0; b_wr_data = 8'(k); b_wr_finish = 1'b1;
      tick;
      b_wr_en = 1'b0; b_wr_finish = 1'b0;
      chk_vec("wrap_wr_bank", 32'(b_wr_bank), (k + 1) % 3);
      chk_vec("wrap_rd_bank", 32'(b_rd_bank), k % 3);
      chk_vec("wrap_full_cnt", 32'(b_full_cnt), 1);
      b_rd_addr = 7'd0;
      tick;
      chk_vec("wrap_rd_data", 32'(b_rd_data), k);
      b_rd_finish = 1'b1;
      tick;
      b_rd_finish = 1'b0;
      chk_vec("wrap_rel_rd_bank", 32'(b_rd_bank), (k + 1) % 3);
      chk_vec("wrap_rel_wr_bank", 32'(b_wr_bank), (k + 1) % 3);
      chk_vec("wrap_rel_full", 32'(b_full_cnt), 0);
    end
    b_rd_finish = 1'b1;
    tick;
    b_rd_finish = 1'b0;
    chk_vec("unf_flag", 32'(b_rd_unf), 1);
    chk_vec("unf_rd_bank", 32'(b_rd_bank), 1);
    chk_vec("unf_full_cnt", 32'(b_full_cnt), 0);
    chk_vec("unf_wr_ovf", 32'(b_wr_ovf), 0);

    // Reset in the middle of a fill, with rd_finish held through the reset edge
    a_wr_en = 1'b1; a_wr_addr = 7'd2; a_wr_data = 8'h22;
    tick;
    a_wr_en = 1'b0;
    rst = 1'b1; a_rd_finish = 1'b1;
    tick;
    rst = 1'b0; a_rd_finish = 1'b0;
    chk_vec("mrst_full_cnt", 32'(a_full_cnt), 0);
    chk_vec("mrst_wr_bank", 32'(a_wr_bank), 0);
    chk_vec("mrst_rd_bank", 32'(a_rd_bank), 0);
    chk_vec("mrst_rd_len", 32'(a_rd_len), 0);
    chk_vec("mrst_rd_ready", 32'(a_rd_ready), 0);
    chk_vec("mrst_wr_ready", 32'(a_wr_ready), 1);
    chk_vec("mrst_rd_unf", 32'(a_rd_unf), 0);
    chk_vec("mrst_wr_ovf", 32'(a_wr_ovf), 0);
    tick;
    chk_vec("mrst_rd_unf_after", 32'(a_rd_unf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
